// File: rtl/mcu_spi_target.sv
// SPI target, mode 0, MSB first, oversampled by clk32.
// Deserialises MOSI bytes and serialises reply bytes onto MISO.
module mcu_spi_target #(
    parameter int   SYNC_STAGES = 2,
    parameter logic MISO_IDLE   = 1'b1
) (
    input  logic       clk32,
    input  logic       reset_n,
    input  logic       spi_sclk,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    output logic       tx_ack,
    output logic       frame_start,
    output logic       frame_end,
    output logic       busy
);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   sclk_prev_q;
    logic                   csn_prev_q;

    state_t     state_q, state_d;
    logic       armed_q, armed_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       first_q, first_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       rx_first_q, rx_first_d;
    logic       tx_ack_q, tx_ack_d;
    logic       fs_q, fs_d;
    logic       fe_q, fe_d;

    logic sclk_s, csn_s, mosi_s, filled;
    logic sclk_rise, sclk_fall, csn_rise, csn_fall;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign csn_s  = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
    // csn_s holds its reset value until the chain has refilled
    assign filled = fill_q[SYNC_STAGES-1];

    assign sclk_rise = ~sclk_prev_q & sclk_s;
    assign sclk_fall = sclk_prev_q & ~sclk_s;
    assign csn_rise  = ~csn_prev_q & csn_s;
    assign csn_fall  = csn_prev_q & ~csn_s;

    always_ff @(posedge clk32) begin
        if (!reset_n) begin
            sclk_sync_q <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            csn_prev_q  <= 1'b1;
            state_q     <= IDLE;
            armed_q     <= 1'b0;
            bit_cnt_q   <= 3'd0;
            rx_shift_q  <= 8'd0;
            tx_shift_q  <= 8'd0;
            first_q     <= 1'b0;
            rx_data_q   <= 8'd0;
            rx_valid_q  <= 1'b0;
            rx_first_q  <= 1'b0;
            tx_ack_q    <= 1'b0;
            fs_q        <= 1'b0;
            fe_q        <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], spi_csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            csn_prev_q  <= csn_s;
            state_q     <= state_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            first_q     <= first_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            rx_first_q  <= rx_first_d;
            tx_ack_q    <= tx_ack_d;
            fs_q        <= fs_d;
            fe_q        <= fe_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | (filled & csn_s);
        bit_cnt_d  = bit_cnt_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        first_d    = first_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_first_d = 1'b0;
        tx_ack_d   = 1'b0;
        fs_d       = 1'b0;
        fe_d       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (csn_fall && armed_q) begin
                    state_d    = ACTIVE;
                    fs_d       = 1'b1;
                    bit_cnt_d  = 3'd0;
                    first_d    = 1'b1;
                    tx_shift_d = tx_data;
                    tx_ack_d   = 1'b1;
                end
            end
            ACTIVE: begin
                // csn rise outranks any coincident sclk edge
                if (csn_rise) begin
                    state_d = IDLE;
                    fe_d    = 1'b1;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[6:0], mosi_s};
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_data_d  = {rx_shift_q[6:0], mosi_s};
                        rx_valid_d = 1'b1;
                        rx_first_d = first_q;
                        first_d    = 1'b0;
                    end
                end else if (sclk_fall) begin
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_d = tx_data;
                        tx_ack_d   = 1'b1;
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso    = (state_q == ACTIVE) ? tx_shift_q[7] : MISO_IDLE;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_first    = rx_first_q;
    assign tx_ack      = tx_ack_q;
    assign frame_start = fs_q;
    assign frame_end   = fe_q;
    assign busy        = (state_q == ACTIVE);

endmodule

// File: tb/tb_mcu_spi_target.sv
// Directed bench for mcu_spi_target: single-byte vector table
// plus hand sequences for reset, multi-byte, abort and collision cases.
module tb_mcu_spi_target;

    logic       clk32;
    logic       reset_n;
    logic       spi_sclk;
    logic       spi_csn;
    logic       spi_mosi;
    logic       spi_miso;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic [7:0] tx_data;
    logic       tx_ack;
    logic       frame_start;
    logic       frame_end;
    logic       busy;

    mcu_spi_target dut (
        .clk32      (clk32),
        .reset_n    (reset_n),
        .spi_sclk   (spi_sclk),
        .spi_csn    (spi_csn),
        .spi_mosi   (spi_mosi),
        .spi_miso   (spi_miso),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_first   (rx_first),
        .tx_data    (tx_data),
        .tx_ack     (tx_ack),
        .frame_start(frame_start),
        .frame_end  (frame_end),
        .busy       (busy)
    );

    initial clk32 = 1'b0;
    always #5 clk32 = ~clk32;

    typedef struct {
        logic [7:0] mosi;
        logic [7:0] txd;
        logic [7:0] exp_rx;
        logic [7:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    int n_checks = 0;
    int n_fail   = 0;
    int rx_cnt   = 0;
    int first_cnt = 0;
    int ack_cnt  = 0;
    int fs_cnt   = 0;
    int fe_cnt   = 0;
    logic       last_first;
    logic [7:0] rx_log[$];
    logic [7:0] plan[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk32);
    endtask

    task automatic csn_low();
        spi_csn = 1'b0;
        wait_clk(8);
    endtask

    task automatic csn_high();
        spi_csn = 1'b1;
        wait_clk(8);
    endtask

    // Shift n bits of mo (MSB first) at sclk = clk32/8, capturing MISO
    task automatic spi_bits(input int n, input logic [7:0] mo,
                            output logic [7:0] mi, input bit fall_last);
        mi = 8'd0;
        for (int i = 0; i < n; i++) begin
            spi_mosi = mo[7-i];
            wait_clk(4);
            mi[7-i] = spi_miso;
            spi_sclk = 1'b1;
            wait_clk(4);
            if (i < n - 1 || fall_last) spi_sclk = 1'b0;
        end
    endtask

    // Event monitor and reply-byte responder
    initial begin
        forever begin
            @(negedge clk32);
            if (rx_valid) begin
                rx_cnt++;
                rx_log.push_back(rx_data);
                last_first = rx_first;
                if (rx_first) first_cnt++;
                if (plan.size() > 0) tx_data = plan.pop_front();
            end
            if (tx_ack) ack_cnt++;
            if (frame_start) fs_cnt++;
            if (frame_end) fe_cnt++;
        end
    end

    initial begin
        logic [7:0] mi, m0, m1, m2;
        int rx0, fs0, fe0, ack0, fi0;

        vecs[0] = '{mosi: 8'hA5, txd: 8'h3C, exp_rx: 8'hA5, exp_miso: 8'h3C};
        vecs[1] = '{mosi: 8'h00, txd: 8'hFF, exp_rx: 8'h00, exp_miso: 8'hFF};
        vecs[2] = '{mosi: 8'hFF, txd: 8'h00, exp_rx: 8'hFF, exp_miso: 8'h00};
        vecs[3] = '{mosi: 8'h5A, txd: 8'hA5, exp_rx: 8'h5A, exp_miso: 8'hA5};

        reset_n  = 1'b0;
        spi_csn  = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        tx_data  = 8'h00;

        // Reset with csn held low: no frame until csn seen high
        wait_clk(3);
        check("rst_miso", spi_miso, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        reset_n = 1'b1;
        wait_clk(10);
        spi_bits(8, 8'hC3, mi, 1'b1);
        wait_clk(4);
        check("unarmed_busy", busy, 1'b0);
        check("unarmed_fs", fs_cnt, 0);
        check("unarmed_rx", rx_cnt, 0);
        check("unarmed_miso", spi_miso, 1'b1);
        csn_high();
        csn_low();
        check("armed_fs", fs_cnt, 1);
        check("armed_busy", busy, 1'b1);
        check("armed_ack", ack_cnt, 1);
        csn_high();
        check("armed_fe", fe_cnt, 1);
        check("armed_idle_busy", busy, 1'b0);

        // Single-byte frames from the vector table
        for (int v = 0; v < 4; v++) begin
            rx0 = rx_cnt; fs0 = fs_cnt; fe0 = fe_cnt; ack0 = ack_cnt;
            tx_data = vecs[v].txd;
            csn_low();
            check("vec_fs", fs_cnt - fs0, 1);
            spi_bits(8, vecs[v].mosi, mi, 1'b1);
            wait_clk(4);
            csn_high();
            check("vec_rx_data", rx_data, vecs[v].exp_rx);
            check("vec_rx_first", last_first, 1'b1);
            check("vec_miso", mi, vecs[v].exp_miso);
            check("vec_rx_cnt", rx_cnt - rx0, 1);
            check("vec_fe", fe_cnt - fe0, 1);
            check("vec_ack", ack_cnt - ack0, 2);
            check("vec_idle_miso", spi_miso, 1'b1);
        end

        // Three-byte frame with replies supplied on rx_valid
        rx0 = rx_cnt; ack0 = ack_cnt; fi0 = first_cnt;
        rx_log.delete();
        tx_data = 8'h3C;
        plan.push_back(8'h81);
        plan.push_back(8'h42);
        csn_low();
        spi_bits(8, 8'h12, m0, 1'b1);
        spi_bits(8, 8'h34, m1, 1'b1);
        spi_bits(8, 8'h56, m2, 1'b0);
        check("mb_ack3", ack_cnt - ack0, 3);
        spi_sclk = 1'b0;
        wait_clk(4);
        csn_high();
        check("mb_miso0", m0, 8'h3C);
        check("mb_miso1", m1, 8'h81);
        check("mb_miso2", m2, 8'h42);
        check("mb_rx_cnt", rx_cnt - rx0, 3);
        check("mb_first_cnt", first_cnt - fi0, 1);
        check("mb_last_first", last_first, 1'b0);
        check("mb_rx0", rx_log[0], 8'h12);
        check("mb_rx1", rx_log[1], 8'h34);
        check("mb_rx2", rx_log[2], 8'h56);

        // Abort after 5 bits, then a clean 0xFF frame
        rx0 = rx_cnt; fe0 = fe_cnt;
        tx_data = 8'h00;
        csn_low();
        spi_bits(5, 8'hB0, mi, 1'b1);
        wait_clk(4);
        csn_high();
        check("abort_rx_cnt", rx_cnt - rx0, 0);
        check("abort_fe", fe_cnt - fe0, 1);
        check("abort_miso", spi_miso, 1'b1);
        check("abort_busy", busy, 1'b0);
        csn_low();
        spi_bits(8, 8'hFF, mi, 1'b1);
        wait_clk(4);
        csn_high();
        check("after_abort_rx", rx_data, 8'hFF);
        check("after_abort_first", last_first, 1'b1);
        check("after_abort_cnt", rx_cnt - rx0, 1);

        // csn rise coincident with the 8th sclk rise
        rx0 = rx_cnt; fe0 = fe_cnt;
        csn_low();
        spi_bits(7, 8'h66, mi, 1'b1);
        spi_mosi = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b1;
        spi_csn  = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b0;
        wait_clk(8);
        check("coll_rx_cnt", rx_cnt - rx0, 0);
        check("coll_fe", fe_cnt - fe0, 1);
        check("coll_busy", busy, 1'b0);
        check("coll_miso", spi_miso, 1'b1);

        // Reset mid-byte: the interrupted frame is never resumed
        rx0 = rx_cnt; fs0 = fs_cnt;
        csn_low();
        spi_bits(4, 8'h90, mi, 1'b1);
        reset_n = 1'b0;
        wait_clk(3);
        reset_n = 1'b1;
        wait_clk(4);
        spi_bits(4, 8'hF0, mi, 1'b1);
        wait_clk(4);
        check("midrst_busy", busy, 1'b0);
        check("midrst_rx_cnt", rx_cnt - rx0, 0);
        check("midrst_fs", fs_cnt - fs0, 1);
        csn_high();
        csn_low();
        spi_bits(8, 8'h5A, mi, 1'b1);
        wait_clk(4);
        csn_high();
        check("midrst_rx_data", rx_data, 8'h5A);
        check("midrst_first", last_first, 1'b1);
        check("midrst_rx_cnt2", rx_cnt - rx0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
